// File: rtl/sp_ram_master_if.sv
// Request/response handshake bundle between a requester and sp_ram_master.
// Signal names keep the _i/_o suffixes as seen from sp_ram_master.
interface sp_ram_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [BE_WIDTH-1:0]   req_be_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;

    // Requester side (core / interconnect adapter)
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o
    );

    // sp_ram_master side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o
    );
endinterface

// File: rtl/sp_ram_master.sv
// sp_ram_master: valid/ready initiator for a single-port RAM with a small
// credit-protected response FIFO for read data.
// Optional feature macro: SP_RAM_MASTER_WACK_EN (write acknowledge responses).
module sp_ram_master #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sp_ram_master_if.slave          bus,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PW       = $clog2(RSP_DEPTH);
    localparam int unsigned CW       = PW + 1;

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
    logic                  rd_pend_q, rd_pend_d;
    logic                  wack_pend_q;
`ifdef SP_RAM_MASTER_WACK_EN
    logic                  wack_pend_d;
`endif

    logic [CW-1:0]         occ;
    logic [CW-1:0]         credit;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  needs_rsp;
    logic [DATA_WIDTH-1:0] push_data;

    // FIFO status, credit and request acceptance
    always_comb begin
        occ    = wr_ptr_q - rd_ptr_q;
        pop    = bus.rsp_valid_o && bus.rsp_ready_i;
        credit = occ + CW'(rd_pend_q) + CW'(wack_pend_q) - CW'(pop);
`ifdef SP_RAM_MASTER_WACK_EN
        needs_rsp = 1'b1;
`else
        needs_rsp = !bus.req_we_i;
`endif
        bus.req_ready_o = rst || !needs_rsp || (credit < CW'(RSP_DEPTH));
        accept          = bus.req_valid_i && bus.req_ready_o && !rst;
    end

    // Combinational issue onto the RAM pins; byte enables only matter for writes
    always_comb begin
        ram_en_o    = accept;
        ram_we_o    = bus.req_we_i;
        ram_addr_o  = bus.req_addr_i;
        ram_wdata_o = bus.req_wdata_i;
        ram_be_o    = bus.req_we_i ? bus.req_be_i : BE_WIDTH'(0);
    end

    // Response FIFO head
    always_comb begin
        bus.rsp_valid_o = (occ != CW'(0));
        bus.rsp_rdata_o = mem_q[rd_ptr_q[PW-1:0]];
    end

    // Next state: pending flags, FIFO push/pop; RAM data sampled only when a read is pending
    always_comb begin
        rd_pend_d = accept && !bus.req_we_i;
`ifdef SP_RAM_MASTER_WACK_EN
        wack_pend_d = accept && bus.req_we_i;
`endif
        push      = rd_pend_q || wack_pend_q;
        push_data = rd_pend_q ? ram_rdata_i : DATA_WIDTH'(0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    // State registers; reset drops any read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_pend_q <= rd_pend_d;
            mem_q     <= mem_d;
        end
    end

`ifdef SP_RAM_MASTER_WACK_EN
    // Write-ack pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wack_pend_q <= 1'b0;
        end else begin
            wack_pend_q <= wack_pend_d;
        end
    end
`else
    assign wack_pend_q = 1'b0;
`endif

`ifndef SYNTHESIS
    // Credit scheme must make overflow unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ == CW'(RSP_DEPTH))));
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        occ <= CW'(RSP_DEPTH));
`endif
endmodule

// File: tb/tb_sp_ram_master.sv
// Testbench for sp_ram_master: behavioural RAM, reference memory and an
// in-order scoreboard of expected responses.
module tb_sp_ram_master;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    sp_ram_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_rdata)
    );

    // Behavioural RAM: rdata register changes every cycle, garbage when not reading
    logic [DW-1:0] ram_mem [64];
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (ram_be[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_en && !ram_we) ram_rdata <= ram_mem[ram_addr[7:2]];
        else                   ram_rdata <= $urandom;
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q [$];
    logic          gap_chk = 1'b0;
    int            gap_n = 0;
    int            last_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%08h exp=0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'(1), 32'(0));
            end else begin
                check_eq("rsp_data", bus.rsp_rdata_o, exp_q.pop_front());
            end
            if (gap_chk) begin
                if (gap_n > 0) check_eq("b2b_gap", 32'(cyc - last_pop), 32'(1));
                gap_n++;
            end
            last_pop = cyc;
        end
        if (!gap_chk) gap_n = 0;
    end

    // Present one request, wait (bounded) for acceptance, update the model
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [BW-1:0] be, input string tag, output int waited);
        waited            = 0;
        bus.req_valid_i   = 1'b1;
        bus.req_we_i      = we;
        bus.req_addr_i    = addr;
        bus.req_wdata_i   = data;
        bus.req_be_i      = be;
        @(negedge clk);
        while (!bus.req_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready_o) begin
            check_eq({tag, "_accept_timeout"}, 32'(0), 32'(1));
        end else begin
            check_eq({tag, "_ram_en"}, 32'(ram_en), 32'(1));
            check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr));
            if (!we) begin
                check_eq({tag, "_rd_be"}, 32'(ram_be), 32'(0));
                exp_q.push_back(ref_mem[addr[7:2]]);
            end else begin
                for (int b = 0; b < int'(BW); b++) begin
                    if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
                end
`ifdef SP_RAM_MASTER_WACK_EN
                exp_q.push_back('0);
`endif
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int w;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        rst             = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_be_i    = '1;
        bus.rsp_ready_i = 1'b1;

        // Reset: ready high, RAM enable gated, no response
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(bus.req_ready_o), 32'(1));
        check_eq("rst_ram_en", 32'(ram_en), 32'(0));
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'(0));
        check_eq("rst_rsp_rdata", bus.rsp_rdata_o, 32'(0));
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        rst             = 1'b0;
        idle(2);

        // 1: write then read back, rsp_valid exactly 2 cycles after accept
        do_req(1'b1, 8'h10, 32'hA5A5A5A5, 4'hF, "t1_wr", w);
        idle(3);
        do_req(1'b0, 8'h10, '0, 4'hF, "t1_rd", w);
        @(negedge clk);
        check_eq("t1_lat_cycle1", 32'(bus.rsp_valid_o), 32'(0));
        @(negedge clk);
        check_eq("t1_lat_cycle2", 32'(bus.rsp_valid_o), 32'(1));
        wait_drain("t1");

        // 2: partial byte-enable write merges into existing word
        do_req(1'b1, 8'h20, 32'h11223344, 4'hF, "t2_wr0", w);
        do_req(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0100, "t2_wr1", w);
        do_req(1'b0, 8'h20, '0, 4'hF, "t2_rd", w);
        wait_drain("t2");

        // 3: four back-to-back reads, never stalled, consecutive in-order responses
        for (int i = 0; i < 4; i++) do_req(1'b1, AW'(4 * i), 32'hC0DE0000 + DW'(i), 4'hF, "t3_wr", w);
        wait_drain("t3_pre");
        gap_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, AW'(4 * i), '0, 4'hF, "t3_rd", w);
            check_eq("t3_no_stall", 32'(w), 32'(0));
        end
        wait_drain("t3");
        idle(1);
        gap_chk = 1'b0;

        // 4: back-pressure limits accepted reads to the FIFO depth
        do_req(1'b1, 8'h40, 32'h40404040, 4'hF, "t4_wr0", w);
        do_req(1'b1, 8'h44, 32'h44444444, 4'hF, "t4_wr1", w);
        do_req(1'b1, 8'h48, 32'h48484848, 4'hF, "t4_wr2", w);
        wait_drain("t4_pre");
        bus.rsp_ready_i = 1'b0;
        do_req(1'b0, 8'h40, '0, 4'hF, "t4_rd0", w);
        check_eq("t4_rd0_nowait", 32'(w), 32'(0));
        do_req(1'b0, 8'h44, '0, 4'hF, "t4_rd1", w);
        check_eq("t4_rd1_nowait", 32'(w), 32'(0));
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 8'h48;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t4_full_ready", 32'(bus.req_ready_o), 32'(0));
            check_eq("t4_full_ram_en", 32'(ram_en), 32'(0));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check_eq("t4_pop_cycle_ready", 32'(bus.req_ready_o), 32'(1));
        check_eq("t4_pop_cycle_ram_en", 32'(ram_en), 32'(1));
        if (bus.req_ready_o) exp_q.push_back(ref_mem[8'h48 >> 2]);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        wait_drain("t4");

        // 5: reset while a read is in flight drops it and restores full credit
        do_req(1'b0, 8'h10, '0, 4'hF, "t5_rd", w);
        rst = 1'b1;
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t5_no_stale_rsp", 32'(bus.rsp_valid_o), 32'(0));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
        do_req(1'b0, 8'h10, '0, 4'hF, "t5_cr0", w);
        check_eq("t5_credit0", 32'(w), 32'(0));
        do_req(1'b0, 8'h20, '0, 4'hF, "t5_cr1", w);
        check_eq("t5_credit1", 32'(w), 32'(0));
        bus.rsp_ready_i = 1'b1;
        wait_drain("t5");

        // 6: write immediately followed by read of the same address
        do_req(1'b1, 8'h60, 32'hCAFEF00D, 4'hF, "t6_wr", w);
        do_req(1'b0, 8'h60, '0, 4'hF, "t6_rd", w);
        wait_drain("t6");

        idle(5);
        check_eq("end_rsp_valid", 32'(bus.rsp_valid_o), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
